keypad_code_buffer: RTL
=======================

Name: keypad_code_buffer

Overview:
- Sits directly downstream of the hex keypad scanner and consumes its Code[3:0]/Valid pair.
- Qualifies each keypress with a stability check, so one physical press produces exactly one entry.
- Stores entries in a small first-word-fall-through FIFO and presents them on a valid/ready interface to the consumer (display/command logic).
- Also provides an occupancy count and a sticky overflow flag.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- DEBOUNCE_CYCLES, 4, consecutive identical Valid=1 samples required to accept a press, and consecutive Valid=0 samples required to accept a release; minimum 1.
- REPEAT_DELAY, 64, cycles from accept to first auto-repeat (used only with the optional feature).
- REPEAT_PERIOD, 16, cycles between subsequent auto-repeats (used only with the optional feature).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- Code  in  4  key code from the scanner.
- Valid  in  1  scanner code valid.
- clear  in  1  synchronous flush of FIFO and overflow flag; the FSM is not affected.
- key_data  out  4  head-of-FIFO code.
- key_valid  out  1  FIFO not empty.
- key_ready  in  1  consumer accepts the head entry.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky; a push was dropped because the FIFO was full.

Behaviour:
- Reset (reset=1 sampled at an edge) forces the following, regardless of other inputs:
  - state=IDLE; qualify counter=0; latched code=0.
  - FIFO read and write pointers=0.
  - Outputs: key_valid=0, key_data=0, count=0, overflow=0.
- FSM states: IDLE, QUALIFY, HELD, RELEASE.
- IDLE:
  - Valid=1 latches Code and sets cnt=1.
  - If DEBOUNCE_CYCLES=1, push immediately and go to HELD; otherwise go to QUALIFY.
- QUALIFY:
  - Valid=1 and Code==latched: cnt+1. When the sample count reaches DEBOUNCE_CYCLES, push the latched code and go to HELD.
  - Valid=1 and Code!=latched: relatch the new Code, cnt=1, stay in QUALIFY.
  - Valid=0: go to IDLE with no push.
- HELD:
  - Valid=1 (any Code): stay; no further pushes.
  - Valid=0: go to RELEASE with cnt=1.
- RELEASE:
  - Valid=0: cnt+1. When the count reaches DEBOUNCE_CYCLES, go to IDLE.
  - Valid=1: go back to HELD (treated as bounce; no push).
- Press latency: the push occurs on the edge that samples the DEBOUNCE_CYCLES-th consecutive matching high sample. key_valid rises immediately after that edge. With the default of 4, key_valid is high 4 edges after Valid is first sampled high.
- FIFO is first-word-fall-through:
  - key_data = mem[rd_ptr] whenever key_valid=1; key_data is don't-care when key_valid=0.
  - Pop on key_valid & key_ready.
  - Pointers wrap modulo DEPTH; an extra wrap bit distinguishes full from empty.
- Push while full:
  - Without a pop in the same cycle: data is dropped, overflow is set to 1, pointers are unchanged.
  - With a pop in the same cycle: both operations occur, count is unchanged, no overflow.
- Push while empty with key_ready=1: the entry is not bypassed; it appears on the next cycle.
- key_ready while empty: ignored; count does not underflow.
- clear=1:
  - Pointers=0, count=0, overflow=0.
  - A push in the same cycle is discarded.
  - A press in progress continues; a later accept pushes normally.
- Reset mid-press discards the press. A key still held after reset is requalified from IDLE and does produce a push.

Optional Feature:
- Macro: KEYPAD_CODE_BUFFER_REPEAT_EN.
- When defined (auto-repeat enabled):
  - HELD runs a repeat counter starting at accept.
  - After REPEAT_DELAY cycles in HELD, push the latched code again, then again every REPEAT_PERIOD cycles while in HELD.
  - The counter resets on entry to RELEASE.
  - A return from RELEASE to HELD resumes the period count from 0 with no new delay.
  - Full-FIFO drop rules apply to repeated pushes.
- When undefined:
  - Exactly one push per press; the repeat counter logic is absent.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored.

Test Plan:
- Single press: Code=4'h5, Valid=1 held 10 cycles, key_ready=0 -> key_valid rises after 4th high sample; key_data=5; count=1; no second entry; after Valid=0 for 4 cycles, FSM returns to IDLE.
- Bounce: Valid high 2 cycles, low 1, high 2, low -> no push; count=0; key_valid=0 throughout.
- Code change in QUALIFY: Code=3 for 2 cycles then Code=9 for 4 cycles -> exactly one entry, key_data=9.
- Overflow: 5 qualified presses (codes 1,2,3,4,5) with key_ready=0, DEPTH=4 -> count=4, overflow=1; popping returns 1,2,3,4 in order; then key_valid=0; pulsing clear sets overflow=0.
- Full with simultaneous pop: FIFO full; the 5th press accept cycle coincides with key_ready=1 -> count stays 4, overflow=0; pop order is 2,3,4,5.
- Reset mid-operation: reset during HELD with 2 entries queued -> next cycle count=0, key_valid=0, overflow=0; Valid still 1 -> requalified, and after 4 samples one new entry.

Source files
------------

// File: rtl/keypad_code_buffer_if.sv
// Scanner-side inputs and consumer-side FIFO handshake of keypad_code_buffer.
// valid/ready: an entry transfers on every rising edge where key_valid and key_ready are both 1.
interface keypad_code_buffer_if #(
    parameter int DEPTH = 4
) ();
    logic [3:0]                   Code;
    logic                         Valid;
    logic                         clear;
    logic [3:0]                   key_data;
    logic                         key_valid;
    logic                         key_ready;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         overflow;
    logic [1:0]                   state_dbg;

    modport slave (
        input  Code, Valid, clear, key_ready,
        output key_data, key_valid, count, overflow, state_dbg
    );

    modport master (
        output Code, Valid, clear, key_ready,
        input  key_data, key_valid, count, overflow, state_dbg
    );
endinterface

// File: rtl/keypad_code_buffer.sv
// Debounced keypress qualifier feeding a first-word-fall-through FIFO.
// Optional auto-repeat while a key is held: define KEYPAD_CODE_BUFFER_REPEAT_EN.
module keypad_code_buffer #(
    parameter int DEPTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input logic                  clock,
    input logic                  reset,
    keypad_code_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DC = CW'(DEBOUNCE_CYCLES);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
        $error("keypad_code_buffer: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [3:0]      code_q, code_d;
    logic            push;

    logic [3:0]      mem_q [DEPTH];
    logic [AW:0]     wr_q, rd_q;
    logic            ovf_q;
    logic            empty, full, pop, do_push;

    assign cnt_inc = cnt_q + CW'(1);

`ifdef KEYPAD_CODE_BUFFER_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
    logic          rep_armed_q, rep_armed_d;
    assign rep_inc = rep_cnt_q + RW'(1);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        push    = 1'b0;
`ifdef KEYPAD_CODE_BUFFER_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.Valid) begin
                    code_d = bus.Code;
                    cnt_d  = CW'(1);
                    if (DEBOUNCE_CYCLES == 1) begin
                        push    = 1'b1;
                        state_d = HELD;
`ifdef KEYPAD_CODE_BUFFER_REPEAT_EN
                        rep_cnt_d   = '0;
                        rep_armed_d = 1'b0;
`endif
                    end else begin
                        state_d = QUALIFY;
                    end
                end
            end
            QUALIFY: begin
                if (!bus.Valid) begin
                    state_d = IDLE;
                end else if (bus.Code != code_q) begin
                    code_d = bus.Code;
                    cnt_d  = CW'(1);
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DC) begin
                        push    = 1'b1;
                        state_d = HELD;
`ifdef KEYPAD_CODE_BUFFER_REPEAT_EN
                        rep_cnt_d   = '0;
                        rep_armed_d = 1'b0;
`endif
                    end
                end
            end
            HELD: begin
                if (!bus.Valid) begin
                    cnt_d   = CW'(1);
                    state_d = (DEBOUNCE_CYCLES == 1) ? IDLE : RELEASE;
`ifdef KEYPAD_CODE_BUFFER_REPEAT_EN
                    rep_cnt_d = '0;
`endif
                end else begin
`ifdef KEYPAD_CODE_BUFFER_REPEAT_EN
                    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
                    if ((!rep_armed_q && rep_inc == RW'(REPEAT_DELAY)) ||
                        ( rep_armed_q && rep_inc == RW'(REPEAT_PERIOD))) begin
                        push        = 1'b1;
                        rep_armed_d = 1'b1;
                        rep_cnt_d   = '0;
                    end else begin
                        rep_cnt_d = rep_inc;
                    end
`endif
                end
            end
            RELEASE: begin
                if (bus.Valid) begin
                    state_d = HELD;
`ifdef KEYPAD_CODE_BUFFER_REPEAT_EN
                    rep_cnt_d   = '0;
                    rep_armed_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= DC) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = !empty && bus.key_ready;
    assign do_push = push && (!full || pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
`ifdef KEYPAD_CODE_BUFFER_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
`ifdef KEYPAD_CODE_BUFFER_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
`endif
            // clear flushes the FIFO only; the press tracker keeps running.
            if (bus.clear) begin
                wr_q  <= '0;
                rd_q  <= '0;
                ovf_q <= 1'b0;
            end else begin
                if (pop)              rd_q  <= rd_q + 1'b1;
                if (do_push)          wr_q  <= wr_q + 1'b1;
                if (push && !do_push) ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !bus.clear && do_push) mem_q[wr_q[AW-1:0]] <= code_d;
    end

    assign bus.key_valid = !empty;
    assign bus.key_data  = empty ? 4'h0 : mem_q[rd_q[AW-1:0]];
    assign bus.count     = wr_q - rd_q;
    assign bus.overflow  = ovf_q;
    assign bus.state_dbg = state_q;
endmodule
